sayac_hakem: RTL and testbench

SAYAC_HAKEM -- requirements
Module: sayac_hakem

---
 rtl/sayac_hakem.sv | 132 +++++++++++++
 tb/tb_sayac_hakem.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sayac_hakem.sv
// rtl/sayac_hakem.sv - shared up/down step counter serving two requesters
// Optional: define SAYAC_HAKEM_SABIT_ONCELIK_EN for fixed priority (requester 0 wins) instead of round-robin.
module sayac_hakem (
  input  logic       saat,
  input  logic       reset,
  input  logic       istek0,
  input  logic       istek1,
  input  logic [7:0] baslangic0,
  input  logic [7:0] baslangic1,
  input  logic       yon0,
  input  logic       yon1,
  input  logic [2:0] miktar0,
  input  logic [2:0] miktar1,
  input  logic [3:0] adim0,
  input  logic [3:0] adim1,
  output logic       kabul0,
  output logic       kabul1,
  output logic       bitti0,
  output logic       bitti1,
  output logic [7:0] sonuc0,
  output logic [7:0] sonuc1,
  output logic       mesgul
);

  typedef enum logic [1:0] {BOS, SAY, BITIR} durum_t;

  durum_t     durum, durum_next;
  logic [7:0] deger;
  logic [3:0] kalan;
  logic [2:0] miktar_r;
  logic       yon_r;
  logic       sahip;
  logic       kazanan;
  logic       verilir;
  logic [7:0] sec_baslangic;
  logic [3:0] sec_adim;
  logic [2:0] sec_miktar;
  logic       sec_yon;

`ifndef SAYAC_HAKEM_SABIT_ONCELIK_EN
  logic       son_kabul;
`endif

  assign sec_baslangic = kazanan ? baslangic1 : baslangic0;
  assign sec_adim      = kazanan ? adim1      : adim0;
  assign sec_miktar    = kazanan ? miktar1    : miktar0;
  assign sec_yon       = kazanan ? yon1       : yon0;
  assign mesgul        = (durum != BOS);

  always_comb begin
    verilir    = 1'b0;
    kazanan    = 1'b0;
    durum_next = durum;
    case (durum)
      BOS: begin
        if (istek0 || istek1) begin
          verilir = 1'b1;
`ifdef SAYAC_HAKEM_SABIT_ONCELIK_EN
          kazanan = !istek0;
`else
          // On contention the requester not served last time wins.
          kazanan = (istek0 && istek1) ? !son_kabul : istek1;
`endif
          durum_next = (sec_adim != 4'd0) ? SAY : BITIR;
        end
      end
      SAY:     if (kalan == 4'd1) durum_next = BITIR;
      BITIR:   durum_next = BOS;
      default: durum_next = BOS;
    endcase
  end

  always_ff @(posedge saat) begin
    if (reset) durum <= BOS;
    else       durum <= durum_next;
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      deger     <= 8'd0;
      kalan     <= 4'd0;
      miktar_r  <= 3'd0;
      yon_r     <= 1'b0;
      sahip     <= 1'b0;
      kabul0    <= 1'b0;
      kabul1    <= 1'b0;
      bitti0    <= 1'b0;
      bitti1    <= 1'b0;
      sonuc0    <= 8'd0;
      sonuc1    <= 8'd0;
`ifndef SAYAC_HAKEM_SABIT_ONCELIK_EN
      son_kabul <= 1'b1;
`endif
    end else begin
      kabul0 <= 1'b0;
      kabul1 <= 1'b0;
      bitti0 <= 1'b0;
      bitti1 <= 1'b0;
      case (durum)
        BOS: begin
          if (verilir) begin
            deger     <= sec_baslangic;
            kalan     <= sec_adim;
            miktar_r  <= sec_miktar;
            yon_r     <= sec_yon;
            sahip     <= kazanan;
            kabul0    <= !kazanan;
            kabul1    <= kazanan;
`ifndef SAYAC_HAKEM_SABIT_ONCELIK_EN
            son_kabul <= kazanan;
`endif
          end
        end
        SAY: begin
          deger <= yon_r ? deger + {5'd0, miktar_r} : deger - {5'd0, miktar_r};
          kalan <= kalan - 4'd1;
        end
        BITIR: begin
          if (sahip) begin
            sonuc1 <= deger;
            bitti1 <= 1'b1;
          end else begin
            sonuc0 <= deger;
            bitti0 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sayac_hakem.sv
// tb/tb_sayac_hakem.sv - bench for sayac_hakem: transaction model plus directed and random jobs
module tb_sayac_hakem;

  logic       saat;
  logic       reset;
  logic [1:0] istek;
  logic [7:0] bas [2];
  logic       yon [2];
  logic [2:0] mik [2];
  logic [3:0] adm [2];
  logic       kabul0, kabul1, bitti0, bitti1, mesgul;
  logic [7:0] sonuc0, sonuc1;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 0;

  sayac_hakem dut (
    .saat(saat), .reset(reset),
    .istek0(istek[0]), .istek1(istek[1]),
    .baslangic0(bas[0]), .baslangic1(bas[1]),
    .yon0(yon[0]), .yon1(yon[1]),
    .miktar0(mik[0]), .miktar1(mik[1]),
    .adim0(adm[0]), .adim1(adm[1]),
    .kabul0(kabul0), .kabul1(kabul1),
    .bitti0(bitti0), .bitti1(bitti1),
    .sonuc0(sonuc0), .sonuc1(sonuc1),
    .mesgul(mesgul)
  );

  initial saat = 1'b0;
  always #5 saat = ~saat;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic kab(input int r);
    return (r == 1) ? kabul1 : kabul0;
  endfunction

  function automatic logic bt(input int r);
    return (r == 1) ? bitti1 : bitti0;
  endfunction

  function automatic int son(input int r);
    return (r == 1) ? int'(sonuc1) : int'(sonuc0);
  endfunction

  // Transaction model: a grant books the engine for adim+1 cycles, result is start +/- miktar*adim mod 256.
  logic [1:0] e_kabul, e_bitti;
  logic [7:0] e_sonuc [2];
  int         m_busy = 0;
  int         m_own = 0;
  int         m_last = 1;
  logic [7:0] m_res = 8'd0;

  always @(posedge saat) begin
    int w;
    int t;
    cyc++;
    e_kabul = 2'b00;
    e_bitti = 2'b00;
    if (reset) begin
      m_busy = 0;
      m_last = 1;
      e_sonuc[0] = 8'd0;
      e_sonuc[1] = 8'd0;
    end else if (m_busy == 0) begin
      if (istek != 2'b00) begin
        if (istek == 2'b11) begin
`ifdef SAYAC_HAKEM_SABIT_ONCELIK_EN
          w = 0;
`else
          w = (m_last == 0) ? 1 : 0;
`endif
        end else begin
          w = istek[1] ? 1 : 0;
        end
        e_kabul[w] = 1'b1;
        m_last = w;
        m_own  = w;
        m_busy = int'(adm[w]) + 1;
        t = int'(bas[w]) + (yon[w] ? 1 : -1) * int'(mik[w]) * int'(adm[w]);
        m_res = t[7:0];
      end
    end else begin
      m_busy--;
      if (m_busy == 0) begin
        e_bitti[m_own] = 1'b1;
        e_sonuc[m_own] = m_res;
      end
    end
  end

  always @(negedge saat) begin
    if (chk_en) begin
      check("kabul0", int'(kabul0), int'(e_kabul[0]));
      check("kabul1", int'(kabul1), int'(e_kabul[1]));
      check("bitti0", int'(bitti0), int'(e_bitti[0]));
      check("bitti1", int'(bitti1), int'(e_bitti[1]));
      check("sonuc0", int'(sonuc0), int'(e_sonuc[0]));
      check("sonuc1", int'(sonuc1), int'(e_sonuc[1]));
      check("mesgul", int'(mesgul), (m_busy != 0) ? 1 : 0);
    end
  end

  task automatic do_reset();
    @(negedge saat);
    reset = 1'b1;
    istek = 2'b00;
    @(negedge saat);
    check("rst_mesgul", int'(mesgul), 0);
    check("rst_sonuc0", int'(sonuc0), 0);
    check("rst_sonuc1", int'(sonuc1), 0);
    reset = 1'b0;
  endtask

  task automatic run_job(input int r, input logic [7:0] b, input logic y, input logic [2:0] m,
                         input logic [3:0] a, output int lat, output int res);
    bit seen;
    int t0;
    @(negedge saat);
    istek[r] = 1'b1;
    bas[r] = b; yon[r] = y; mik[r] = m; adm[r] = a;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge saat);
      seen = kab(r);
    end
    check("kabul_seen", int'(seen), 1);
    t0 = cyc;
    istek[r] = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge saat);
      seen = bt(r);
    end
    check("bitti_seen", int'(seen), 1);
    lat = cyc - t0;
    res = son(r);
  endtask

  initial begin
    int lat, res, cnt;
    bit seen;
    int order[$];
    int exp_order [4];

    reset = 1'b1;
    istek = 2'b00;
    for (int r = 0; r < 2; r++) begin
      bas[r] = 8'd0; yon[r] = 1'b0; mik[r] = 3'd0; adm[r] = 4'd0;
    end
    @(negedge saat);
    check("init_kabul0", int'(kabul0), 0);
    check("init_bitti1", int'(bitti1), 0);
    check("init_mesgul", int'(mesgul), 0);
    check("init_sonuc0", int'(sonuc0), 0);
    chk_en = 1;
    reset = 1'b0;

    run_job(0, 8'd10, 1'b1, 3'd3, 4'd4, lat, res);
    check("basic_latency", lat, 5);
    check("basic_sonuc", res, 22);
    run_job(1, 8'd250, 1'b1, 3'd7, 4'd2, lat, res);
    check("wrap_up_sonuc", res, 8);
    run_job(0, 8'd3, 1'b0, 3'd5, 4'd1, lat, res);
    check("wrap_down_sonuc", res, 254);
    check("wrap_down_latency", lat, 2);
    run_job(1, 8'd77, 1'b1, 3'd5, 4'd0, lat, res);
    check("adim0_latency", lat, 1);
    check("adim0_sonuc", res, 77);
    run_job(0, 8'd5, 1'b1, 3'd0, 4'd9, lat, res);
    check("miktar0_sonuc", res, 5);
    check("miktar0_latency", lat, 10);

    // Both requesters held; each re-requests right after its own bitti.
    do_reset();
    bas[0] = 8'd10;  yon[0] = 1'b1; mik[0] = 3'd3; adm[0] = 4'd2;
    bas[1] = 8'd100; yon[1] = 1'b0; mik[1] = 3'd4; adm[1] = 4'd3;
    istek = 2'b11;
    order.delete();
    for (int i = 0; i < 80 && order.size() < 4; i++) begin
      @(negedge saat);
      for (int r = 0; r < 2; r++) begin
        if (kab(r)) begin
          order.push_back(r);
          istek[r] = 1'b0;
        end
        if (bt(r)) istek[r] = 1'b1;
      end
    end
    istek = 2'b00;
`ifdef SAYAC_HAKEM_SABIT_ONCELIK_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    check("grant_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      check("grant_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    for (int i = 0; i < 40 && mesgul; i++) @(negedge saat);
    check("order_sonuc0", int'(sonuc0), 16);
`ifdef SAYAC_HAKEM_SABIT_ONCELIK_EN
    check("order_sonuc1", int'(sonuc1), 0);
`else
    check("order_sonuc1", int'(sonuc1), 88);
`endif

    // Reset on the second SAY cycle aborts the job; a request right at release is served.
    @(negedge saat);
    istek[0] = 1'b1;
    bas[0] = 8'd50; yon[0] = 1'b1; mik[0] = 3'd1; adm[0] = 4'd6;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge saat);
      seen = kabul0;
    end
    check("abort_kabul_seen", int'(seen), 1);
    istek[0] = 1'b0;
    @(negedge saat);
    check("abort_busy_before", int'(mesgul), 1);
    reset = 1'b1;
    @(negedge saat);
    check("abort_bitti0", int'(bitti0), 0);
    check("abort_mesgul", int'(mesgul), 0);
    check("abort_sonuc0", int'(sonuc0), 0);
    check("abort_sonuc1", int'(sonuc1), 0);
    reset = 1'b0;
    istek[1] = 1'b1;
    bas[1] = 8'd200; yon[1] = 1'b0; mik[1] = 3'd2; adm[1] = 4'd3;
    @(negedge saat);
    check("post_reset_kabul1", int'(kabul1), 1);
    istek[1] = 1'b0;
    seen = 0;
    cnt = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge saat);
      seen = bitti1;
      if (bitti0) cnt++;
    end
    check("post_reset_bitti1", int'(seen), 1);
    check("post_reset_sonuc1", int'(sonuc1), 194);
    check("aborted_no_bitti0", cnt, 0);

    // Random traffic against the model, with occasional reset.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      @(negedge saat);
      reset = ($urandom_range(0, 299) == 0);
      for (int r = 0; r < 2; r++) begin
        if (istek[r]) begin
          if (kab(r) && $urandom_range(0, 3) != 0) istek[r] = 1'b0;
        end else begin
          bas[r] = 8'($urandom);
          yon[r] = 1'($urandom_range(0, 1));
          mik[r] = 3'($urandom_range(0, 7));
          adm[r] = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 3) == 0) istek[r] = 1'b1;
        end
      end
    end
    @(negedge saat);
    reset = 1'b0;
    istek = 2'b00;
    repeat (25) @(negedge saat);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
